// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: handshake bus between the arbiter and the unified memory
//   req/we/addr/wdata : arbiter -> memory request, held until ack
//   ack/rdata         : memory -> arbiter completion and read data
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and data ports
//   clk_i, rst_i            : clock, synchronous active-high reset
//   i_req/i_addr/i_ack/i_rdata : read-only fetch port
//   d_req/d_we/d_addr/d_wdata/d_ack/d_rdata : load/store port
//   if_stall_o, mem_stall_o : combinational pipeline stalls
//   err_o                   : pulses with the ack of a timed-out transaction
//   mem                     : memory handshake bus (master side)
module mem_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_ack_o,
    output logic [DATA_W-1:0] i_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              if_stall_o,
    output logic              mem_stall_o,
    output logic              err_o,
    mem_port_arbiter_if.master mem
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;
    localparam logic [3:0] SMAX   = 4'(STARVE_MAX);
    localparam logic [7:0] TMO    = 8'(TIMEOUT);

    logic [1:0]        state_q, state_d;
    logic              req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              i_ack_q, i_ack_d, d_ack_q, d_ack_d, err_q, err_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic [3:0]        starve_q, starve_d;
    logic [7:0]        wait_q, wait_d;
    logic              i_win, done;
    logic [DATA_W-1:0] rd;

    always_comb begin
        // D has priority unless the fetch port has already lost STARVE_MAX times in a row
        i_win     = i_req_i & (~d_req_i | (starve_q == SMAX));
        done      = mem.ack | ((TMO != 8'd0) & (wait_q == TMO));
        rd        = (mem.ack & ~we_q) ? mem.rdata : '0;
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        err_d     = 1'b0;
        i_rdata_d = '0;
        d_rdata_d = '0;
        starve_d  = starve_q;
        wait_d    = 8'd0;
        case (state_q)
            IDLE: begin
                starve_d = i_req_i ? starve_q : 4'd0;
                if (i_win) begin
                    state_d  = BUSY_I;
                    req_d    = 1'b1;
                    we_d     = 1'b0;
                    addr_d   = i_addr_i;
                    wdata_d  = '0;
                    starve_d = 4'd0;
                end else if (d_req_i) begin
                    state_d  = BUSY_D;
                    req_d    = 1'b1;
                    we_d     = d_we_i;
                    addr_d   = d_addr_i;
                    wdata_d  = d_wdata_i;
                    starve_d = ~i_req_i ? 4'd0 : (starve_q == SMAX) ? SMAX : starve_q + 4'd1;
                end
            end
            BUSY_I, BUSY_D: begin
                if (done) begin
                    // bus fields return to 0 so the memory side idles cleanly
                    state_d   = RESP;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    addr_d    = '0;
                    wdata_d   = '0;
                    err_d     = ~mem.ack;
                    i_ack_d   = state_q == BUSY_I;
                    d_ack_d   = state_q == BUSY_D;
                    i_rdata_d = (state_q == BUSY_I) ? rd : '0;
                    d_rdata_d = (state_q == BUSY_D) ? rd : '0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            starve_q  <= 4'd0;
            wait_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            err_q     <= err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            starve_q  <= starve_d;
            wait_q    <= wait_d;
        end
    end

    assign i_ack_o     = i_ack_q;
    assign i_rdata_o   = i_rdata_q;
    assign d_ack_o     = d_ack_q;
    assign d_rdata_o   = d_rdata_q;
    assign err_o       = err_q;
    assign if_stall_o  = i_req_i & ~i_ack_q;
    assign mem_stall_o = d_req_i & ~d_ack_q;
    assign mem.req     = req_q;
    assign mem.we      = we_q;
    assign mem.addr    = addr_q;
    assign mem.wdata   = wdata_q;
endmodule
